// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants for the 1-to-2 buffered demultiplexer and its FIFOs.
//   DEF_DATA_W : default width of a routed data word
//   DEF_CNT_W  : default width of each per-destination transfer counter
//   FIFO_DEPTH : number of entries in each destination buffer
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/demux1_to_2_4bit_buf_if.sv
// ---------------------------------------------------------------------------
// demux1_to_2_4bit_buf_if
// Bundles the source-side and sink-side handshake signals of the buffered
// demultiplexer.
//   master : the environment view. It drives the source word, select and
//            valid, plus both sink readies. It observes in_ready, both output
//            words and valids, and the counters.
//   slave  : the demultiplexer view. It is the mirror image of master.
// ---------------------------------------------------------------------------
interface demux1_to_2_4bit_buf_if
    import mux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic [DATA_W-1:0] out1_data;
    logic              out0_valid;
    logic              out1_valid;
    logic              out0_ready;
    logic              out1_ready;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
    );

endinterface

// File: rtl/demux1_to_2_4bit_buf_fifo2_4bit.sv
// ---------------------------------------------------------------------------
// fifo2_4bit
// Two-entry FIFO used as one destination buffer of the demultiplexer.
//   clk, reset : rising-edge clock and synchronous active-high reset
//   push       : write push_data this cycle; ignored when full
//   push_data  : word to store
//   pop        : drop the head word this cycle; ignored when empty
//   head_data  : oldest stored word, forced to 0 while empty
//   full       : both entries occupied
//   empty      : no entries occupied
// ---------------------------------------------------------------------------
module fifo2_4bit
    import mux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 2'(FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The zero mask keeps stale storage from leaking out after a pop or a reset.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage is written without reset. The zero mask on head_data hides any
    // stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping. On a simultaneous push and pop at
    // count 1, the read pointer moves onto the slot being written. The pushed
    // word becomes the head and the count stays at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux1_to_2_4bit_buf.sv
// ---------------------------------------------------------------------------
// demux1_to_2_4bit_buf
// Routes each source word to one of two destinations. Each destination is
// backed by its own two-entry FIFO and a transfer counter.
//   clk, reset           : rising-edge clock and synchronous active-high reset
//   in_data/in_sel       : source word and destination select (0 -> out0)
//   in_valid/in_ready    : source handshake; ready reflects the selected buffer
//   outk_data/outk_valid : head word of buffer k and its non-empty flag
//   outk_ready           : sink k takes the head word
//   cnt0/cnt1            : wrapping count of words accepted per destination
// ---------------------------------------------------------------------------
module demux1_to_2_4bit_buf
    import mux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic [DATA_W-1:0] out1_data,
    output logic              out0_valid,
    output logic              out1_valid,
    input  logic              out0_ready,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Ready looks only at the selected buffer's full flag. Because of this,
    // a same-cycle pop never opens a full buffer, and no combinational path
    // runs from the sink readies back to the source.
    assign in_ready = in_sel ? !full1 : !full0;

    assign push0 = in_valid && in_ready && !in_sel;
    assign push1 = in_valid && in_ready &&  in_sel;

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    fifo2_4bit #(.DATA_W(DATA_W)) u_buf0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .head_data (out0_data),
        .full      (full0),
        .empty     (empty0)
    );

    fifo2_4bit #(.DATA_W(DATA_W)) u_buf1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .head_data (out1_data),
        .full      (full1),
        .empty     (empty1)
    );

    // Each counter tracks accepted words for its destination and wraps
    // naturally. Reset wins, so words in flight during reset are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (push1) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_demux1_to_2_4bit_buf.sv
// ---------------------------------------------------------------------------
// tb_demux1_to_2_4bit_buf
// Self-checking bench for the buffered 1-to-2 demultiplexer. It runs a
// directed vector table and then hand-written counter-wrap and mid-operation
// reset sequences.
// ---------------------------------------------------------------------------
module tb_demux1_to_2_4bit_buf;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fails  = 0;

    demux1_to_2_4bit_buf_if #(.DATA_W(4), .CNT_W(8)) bus ();

    demux1_to_2_4bit_buf #(.DATA_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (bus.in_data),
        .in_sel     (bus.in_sel),
        .in_valid   (bus.in_valid),
        .in_ready   (bus.in_ready),
        .out0_data  (bus.out0_data),
        .out1_data  (bus.out1_data),
        .out0_valid (bus.out0_valid),
        .out1_valid (bus.out1_valid),
        .out0_ready (bus.out0_ready),
        .out1_ready (bus.out1_ready),
        .cnt0       (bus.cnt0),
        .cnt1       (bus.cnt1)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stops a stuck run with a reported failure instead of hanging.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Each vector holds the inputs to drive and the expected results.
    // exp_rdy is checked before the rising edge. The other expected fields
    // are checked just after the edge.
    typedef struct {
        logic       v;
        logic       sel;
        logic [3:0] d;
        logic       r0;
        logic       r1;
        logic       exp_rdy;
        logic       exp_o0v;
        logic [3:0] exp_o0d;
        logic       exp_o1v;
        logic [3:0] exp_o1d;
        logic [7:0] exp_c0;
        logic [7:0] exp_c1;
    } vec_t;

    vec_t vecs [14];

    // Compares one observed value against its expectation and logs any miss.
    task automatic checkOutput(input string name, input int step,
                               input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    // Drives the inputs at the falling edge and checks in_ready there. It then
    // lets one rising edge pass and checks the registered outputs.
    task automatic applyStimulus(input vec_t t, input int step);
        @(negedge clk);
        bus.in_valid   = t.v;
        bus.in_sel     = t.sel;
        bus.in_data    = t.d;
        bus.out0_ready = t.r0;
        bus.out1_ready = t.r1;
        #1;
        checkOutput("in_ready", step, 32'(bus.in_ready), 32'(t.exp_rdy));
        @(posedge clk);
        #1;
        checkOutput("out0_valid", step, 32'(bus.out0_valid), 32'(t.exp_o0v));
        checkOutput("out0_data",  step, 32'(bus.out0_data),  32'(t.exp_o0d));
        checkOutput("out1_valid", step, 32'(bus.out1_valid), 32'(t.exp_o1v));
        checkOutput("out1_data",  step, 32'(bus.out1_data),  32'(t.exp_o1d));
        checkOutput("cnt0",       step, 32'(bus.cnt0),       32'(t.exp_c0));
        checkOutput("cnt1",       step, 32'(bus.cnt1),       32'(t.exp_c1));
    endtask

    // Holds reset for one rising edge with the inputs given, then confirms
    // that everything came back cleared.
    task automatic pulseReset(input logic v, input logic r0, input logic r1, input int step);
        @(negedge clk);
        reset          = 1'b1;
        bus.in_valid   = v;
        bus.in_sel     = 1'b0;
        bus.in_data    = 4'hF;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        @(posedge clk);
        #1;
        checkOutput("rst out0_valid", step, 32'(bus.out0_valid), 32'd0);
        checkOutput("rst out0_data",  step, 32'(bus.out0_data),  32'd0);
        checkOutput("rst out1_valid", step, 32'(bus.out1_valid), 32'd0);
        checkOutput("rst out1_data",  step, 32'(bus.out1_data),  32'd0);
        checkOutput("rst cnt0",       step, 32'(bus.cnt0),       32'd0);
        checkOutput("rst cnt1",       step, 32'(bus.cnt1),       32'd0);
        @(negedge clk);
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        bus.in_sel     = 1'b0;
        #1;
        checkOutput("post-rst in_ready sel0", step, 32'(bus.in_ready), 32'd1);
        bus.in_sel = 1'b1;
        #1;
        checkOutput("post-rst in_ready sel1", step, 32'(bus.in_ready), 32'd1);
    endtask

    // Offers one word with both sinks stalled. The caller has already
    // worked out that it will be accepted.
    task automatic pushWord(input logic sel, input logic [3:0] d);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_sel     = sel;
        bus.in_data    = d;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               v  sel d      r0  r1  rdy o0v o0d   o1v o1d   c0     c1
        // Basic route to sel 1, then drain it.
        vecs[0]  = '{1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h6, 8'd0, 8'd1};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd0, 8'd1};
        // Fill buffer 0 with its sink stalled; the third word is refused.
        vecs[2]  = '{1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 8'd1, 8'd1};
        vecs[3]  = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 8'd2, 8'd1};
        vecs[4]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0, 8'd2, 8'd1};
        // Isolation: buffer 0 is full and stalled, yet sel 1 still flows.
        vecs[5]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 4'hA, 8'd2, 8'd2};
        // Release sink 0. A pop at full does not admit the pending word.
        vecs[6]  = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 4'hA, 8'd2, 8'd2};
        vecs[7]  = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 8'd3, 8'd2};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd3, 8'd2};
        // Push and pop together on buffer 1 at count 1, then hold while stalled.
        vecs[9]  = '{1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 8'd3, 8'd3};
        vecs[10] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h5, 8'd3, 8'd4};
        vecs[11] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h5, 8'd3, 8'd4};
        vecs[12] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd3, 8'd4};
        // Sink readies while both buffers are empty have no effect.
        vecs[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 8'd3, 8'd4};

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = 4'h0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset state");
        pulseReset(1'b0, 1'b0, 1'b0, 100);

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Stream 256 words into sel 0 with sink 0 always ready. The counter
        // reaches 255 and then wraps back to 0.
        $display("[TB] counter wrap");
        pulseReset(1'b0, 1'b0, 1'b0, 200);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.in_sel     = 1'b0;
            bus.in_data    = 4'(i);
            bus.out0_ready = 1'b1;
            bus.out1_ready = 1'b0;
            #1;
            checkOutput("wrap in_ready", 300 + i, 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
            if (i == 254) begin
                checkOutput("wrap cnt0 at 255", 300 + i, 32'(bus.cnt0), 32'd255);
            end
        end
        checkOutput("wrap cnt0", 556, 32'(bus.cnt0), 32'd0);
        checkOutput("wrap out0_data", 556, 32'(bus.out0_data), 32'hF);
        checkOutput("wrap cnt1", 556, 32'(bus.cnt1), 32'd0);

        // Drain the leftover word, fill both buffers, and check that both
        // now refuse further words.
        $display("[TB] reset mid-operation");
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("drain out0_valid", 600, 32'(bus.out0_valid), 32'd0);
        pushWord(1'b0, 4'h1);
        pushWord(1'b0, 4'h2);
        pushWord(1'b1, 4'h3);
        pushWord(1'b1, 4'h4);
        checkOutput("full cnt0", 601, 32'(bus.cnt0), 32'd2);
        checkOutput("full cnt1", 601, 32'(bus.cnt1), 32'd2);
        checkOutput("full out0_data", 601, 32'(bus.out0_data), 32'h1);
        checkOutput("full out1_data", 601, 32'(bus.out1_data), 32'h3);
        @(negedge clk);
        bus.in_sel = 1'b0;
        #1;
        checkOutput("full in_ready sel0", 602, 32'(bus.in_ready), 32'd0);
        bus.in_sel = 1'b1;
        #1;
        checkOutput("full in_ready sel1", 602, 32'(bus.in_ready), 32'd0);
        // Reset arrives together with a push and both pops; reset must win.
        pulseReset(1'b1, 1'b1, 1'b1, 603);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/demux1_to_2_4bit_buf.md
DEMUX1_TO_2_4BIT_BUF -- requirements
Module: demux1_to_2_4bit_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 4: width of the routed data word.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-destination transfer counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, DATA_W: source word.
REQ-006 SHALL have port in_sel, input, 1: destination select (0 -> out0, 1 -> out1).
REQ-007 SHALL have port in_valid, input, 1: source offers in_data/in_sel this cycle.
REQ-008 SHALL have port in_ready, output, 1: the selected destination buffer can accept this cycle.
REQ-009 SHALL have ports out0_data and out1_data, output, DATA_W: head word of each destination buffer.
REQ-010 SHALL have ports out0_valid and out1_valid, output, 1: the destination buffer is non-empty.
REQ-011 SHALL have ports out0_ready and out1_ready, input, 1: the sink takes the head word.
REQ-012 SHALL have ports cnt0 and cnt1, output, CNT_W: number of words accepted per destination.

Function
REQ-013 SHALL accept a word when in_valid && in_ready at a rising edge, pushing in_data into buffer[in_sel] only.
REQ-014 SHALL drive in_ready = !full[in_sel] combinationally, with no combinational path from out0_ready or out1_ready.
REQ-015 SHALL give each destination an independent 2-entry FIFO; counts are 0, 1 or 2.
REQ-016 SHALL pop buffer k when outk_valid && outk_ready at a rising edge.
REQ-017 SHALL give a latency of 1 cycle: a word accepted at edge N appears on outk_data with outk_valid=1 after edge N if buffer k was empty.
REQ-018 SHALL preserve FIFO order per destination; no ordering is guaranteed between destinations.
REQ-019 SHALL, on simultaneous push and pop of the same buffer with count 1, keep count 1 and present the pushed word as the new head.
REQ-020 SHALL never push to a full buffer, even if it is popped in the same cycle, because in_ready is already 0.
REQ-021 SHALL, when popping an empty buffer (outk_valid=0), ignore outk_ready.
REQ-022 SHALL let a full or stalled buffer block only traffic selecting it; the other destination continues unaffected.
REQ-023 SHALL increment cntk by 1 on each accepted word routed to k, wrapping from 2^CNT_W-1 to 0.
REQ-024 SHALL hold outk_data stable while outk_valid=1 and outk_ready=0.
REQ-025 SHALL drive outk_data to 0 while outk_valid=0.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, clear both FIFOs (count 0, pointers 0) and set cnt0=cnt1=0, out0_valid=out1_valid=0 and out0_data=out1_data=0.
REQ-027 SHALL make in_ready=1 from the first cycle after reset deasserts.
REQ-028 SHALL give reset priority over push and pop in the same cycle; words buffered at reset mid-operation are discarded and not counted.

Structure
REQ-029 SHALL take DATA_W and CNT_W defaults and the FIFO depth constant (2) from a shared package (mux_pkg).
REQ-030 SHALL implement each destination buffer as one instance of a sub-module fifo2_4bit (push, pop, data, full, empty), instantiated twice.

Verification
REQ-031 SHALL cover the basic route: reset, then in_data=4'b0110, in_sel=1, valid for 1 cycle -> out1_valid=1, out1_data=0110 next cycle; out0_valid=0; cnt1=1, cnt0=0.
REQ-032 SHALL cover fill and backpressure: out0_ready=0, send 0001, 0010, 0011 to sel 0 -> first two accepted, in_ready=0 on the third; raise out0_ready -> 0001 then 0010 delivered, then 0011 accepted; cnt0=3.
REQ-033 SHALL cover isolation: buffer 0 full and stalled, send 1010 to sel 1 -> accepted, out1_data=1010; buffer 0 contents unchanged.
REQ-034 SHALL cover push/pop on count 1: buffer 1 holds 0100, out1_ready=1, push 0101 the same cycle -> next cycle out1_data=0101, count 1.
REQ-035 SHALL cover counter wrap: 256 accepted words to sel 0 -> cnt0 returns to 0.
REQ-036 SHALL cover reset mid-operation: both buffers full, assert reset for 1 cycle -> all valid=0, data=0, cnt=0; in_ready=1 the following cycle.
